// File: rtl/jtbubl_vtiming.sv
// jtbubl_vtiming: pixel/line counters, blanking, syncs and frame counter for the video timing chain.
module jtbubl_vtiming #(
    parameter int W         = 9,
    parameter int CEN_DIV   = 8,
    parameter int H_END     = 383,
    parameter int H_ACT     = 256,
    parameter int HS_START  = 300,
    parameter int HS_LEN    = 32,
    parameter int V_START   = 16,
    parameter int V_END     = 279,
    parameter int VB_START  = 240,
    parameter int VB_END    = 16,
    parameter int VS_START  = 255,
    parameter int VS_LEN    = 3,
    parameter int BLANK_DLY = 2
) (
    input  logic         clk,
    input  logic         rst,
    output logic         pxl_cen,
    output logic         pxl2_cen,
    output logic [W-1:0] hdump,
    output logic [W-1:0] vdump,
    output logic [W-1:0] vrender,
    output logic         LHBL,
    output logic         LVBL,
    output logic         HS,
    output logic         VS,
    output logic         LHBL_dly,
    output logic         LVBL_dly,
    output logic         Hinit,
    output logic         Vinit,
    output logic [7:0]   frame_cnt
);
    if (W < 1 || H_END >= 2**W || V_END >= 2**W || V_END <= V_START || CEN_DIV < 2 || CEN_DIV % 2 != 0 ||
        H_ACT > H_END + 1 || HS_LEN < 1 || HS_START + HS_LEN > H_END + 1 || VS_LEN < 1 ||
        VS_START < V_START || VS_START + VS_LEN > V_END || BLANK_DLY < 0 || BLANK_DLY > 15) begin : g_bad
        $error("jtbubl_vtiming: illegal parameter set");
    end

    localparam int DW = $clog2(CEN_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CEN_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(CEN_DIV / 2 - 1);
    localparam logic [W-1:0] HE  = W'(H_END);
    localparam logic [W-1:0] VE  = W'(V_END);
    localparam logic [W-1:0] VS0 = W'(V_START);
    localparam logic [W-1:0] VR0 = W'(V_START + 1);
    // Upper bounds may equal 2**W, so window compares use one extra bit
    localparam logic [W:0] HA  = (W+1)'(H_ACT);
    localparam logic [W:0] HSS = (W+1)'(HS_START);
    localparam logic [W:0] HSE = (W+1)'(HS_START + HS_LEN);
    localparam logic [W:0] VBE = (W+1)'(VB_END);
    localparam logic [W:0] VBS = (W+1)'(VB_START);
    localparam logic [W:0] VSS = (W+1)'(VS_START);
    localparam logic [W:0] VSE = (W+1)'(VS_START + VS_LEN);
    localparam logic LH0 = H_ACT > 0;
    localparam logic LV0 = V_START >= VB_END && V_START < VB_START;

    logic [DW-1:0] div_q, div_d;
    logic          cen_q, cen2_q;
    logic [W-1:0]  h_q, h_d, v_q, v_d, vr_q;
    logic [W:0]    hx, vx;
    logic          lhbl_q, lvbl_q, hs_q, vs_q, hinit_q, vinit_q, vtop_d;
    logic [7:0]    frame_q;

    always_comb begin
        div_d  = div_q == DIV_LAST ? '0 : div_q + 1'b1;
        h_d    = h_q == HE ? '0 : h_q + 1'b1;
        v_d    = h_q != HE ? v_q : v_q == VE ? VS0 : v_q + 1'b1;
        hx     = {1'b0, h_d};
        vx     = {1'b0, v_d};
        vtop_d = h_d == '0 && v_d == VS0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q   <= '0;
            cen_q   <= 1'b0;
            cen2_q  <= 1'b0;
            h_q     <= '0;
            v_q     <= VS0;
            vr_q    <= VR0;
            lhbl_q  <= LH0;
            lvbl_q  <= LV0;
            hs_q    <= 1'b0;
            vs_q    <= 1'b0;
            hinit_q <= 1'b0;
            vinit_q <= 1'b0;
            frame_q <= '0;
        end else begin
            div_q  <= div_d;
            cen_q  <= div_d == DIV_LAST;
            cen2_q <= div_d == DIV_LAST || div_d == DIV_HALF;
            if (cen_q) begin
                h_q     <= h_d;
                v_q     <= v_d;
                vr_q    <= v_d == VE ? VS0 : v_d + 1'b1;
                lhbl_q  <= hx < HA;
                lvbl_q  <= vx >= VBE && vx < VBS;
                hs_q    <= hx >= HSS && hx < HSE;
                vs_q    <= hx == HSS ? vx >= VSS && vx < VSE : vs_q;
                hinit_q <= h_d == '0;
                vinit_q <= vtop_d;
                frame_q <= frame_q + 8'(vtop_d);
            end
        end
    end

    if (BLANK_DLY == 0) begin : g_nodly
        assign LHBL_dly = lhbl_q;
        assign LVBL_dly = lvbl_q;
    end else begin : g_dly
        logic [BLANK_DLY-1:0] hsr_q, vsr_q;
        always_ff @(posedge clk) begin
            if (rst) begin
                hsr_q <= {BLANK_DLY{LH0}};
                vsr_q <= {BLANK_DLY{LV0}};
            end else if (cen_q) begin
                hsr_q <= (hsr_q << 1) | BLANK_DLY'(lhbl_q);
                vsr_q <= (vsr_q << 1) | BLANK_DLY'(lvbl_q);
            end
        end
        assign LHBL_dly = hsr_q[BLANK_DLY-1];
        assign LVBL_dly = vsr_q[BLANK_DLY-1];
    end

    assign pxl_cen   = cen_q;
    assign pxl2_cen  = cen2_q;
    assign hdump     = h_q;
    assign vdump     = v_q;
    assign vrender   = vr_q;
    assign LHBL      = lhbl_q;
    assign LVBL      = lvbl_q;
    assign HS        = hs_q;
    assign VS        = vs_q;
    assign Hinit     = hinit_q;
    assign Vinit     = vinit_q;
    assign frame_cnt = frame_q;
endmodule

// File: tb/tb_jtbubl_vtiming.sv
// tb_jtbubl_vtiming: directed checks of the default timing plus a shrunken timing for frame-level behaviour.
module tb_jtbubl_vtiming;
    logic clk = 1'b0;
    logic rst_d = 1'b1;
    logic rst_s = 1'b1;
    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    logic       d_cen, d_cen2, d_lh, d_lv, d_hs, d_vs, d_lhd, d_lvd, d_hi, d_vi;
    logic [8:0] d_h, d_v, d_vr;
    logic [7:0] d_fc;
    logic       s_cen, s_cen2, s_lh, s_lv, s_hs, s_vs, s_lhd, s_lvd, s_hi, s_vi;
    logic [4:0] s_h, s_v, s_vr;
    logic [7:0] s_fc;
    logic       z_cen, z_cen2, z_lh, z_lv, z_hs, z_vs, z_lhd, z_lvd, z_hi, z_vi;
    logic [4:0] z_h, z_v, z_vr;
    logic [7:0] z_fc;

    jtbubl_vtiming u_def (
        .clk(clk), .rst(rst_d), .pxl_cen(d_cen), .pxl2_cen(d_cen2), .hdump(d_h), .vdump(d_v), .vrender(d_vr),
        .LHBL(d_lh), .LVBL(d_lv), .HS(d_hs), .VS(d_vs), .LHBL_dly(d_lhd), .LVBL_dly(d_lvd),
        .Hinit(d_hi), .Vinit(d_vi), .frame_cnt(d_fc)
    );

    jtbubl_vtiming #(.W(5), .CEN_DIV(2), .H_END(11), .H_ACT(8), .HS_START(9), .HS_LEN(2), .V_START(2),
        .V_END(9), .VB_START(8), .VB_END(3), .VS_START(6), .VS_LEN(2), .BLANK_DLY(2)) u_sm (
        .clk(clk), .rst(rst_s), .pxl_cen(s_cen), .pxl2_cen(s_cen2), .hdump(s_h), .vdump(s_v), .vrender(s_vr),
        .LHBL(s_lh), .LVBL(s_lv), .HS(s_hs), .VS(s_vs), .LHBL_dly(s_lhd), .LVBL_dly(s_lvd),
        .Hinit(s_hi), .Vinit(s_vi), .frame_cnt(s_fc)
    );

    jtbubl_vtiming #(.W(5), .CEN_DIV(2), .H_END(11), .H_ACT(8), .HS_START(9), .HS_LEN(2), .V_START(2),
        .V_END(9), .VB_START(8), .VB_END(3), .VS_START(6), .VS_LEN(2), .BLANK_DLY(0)) u_s0 (
        .clk(clk), .rst(rst_s), .pxl_cen(z_cen), .pxl2_cen(z_cen2), .hdump(z_h), .vdump(z_v), .vrender(z_vr),
        .LHBL(z_lh), .LVBL(z_lv), .HS(z_hs), .VS(z_vs), .LHBL_dly(z_lhd), .LVBL_dly(z_lvd),
        .Hinit(z_hi), .Vinit(z_vi), .frame_cnt(z_fc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Stops just after the enable edge that loads the requested position
    task automatic run_def(input int h, input int v);
        logic prev;
        logic hit = 1'b0;
        int n = 0;
        while (!hit && n < 4000) begin
            prev = d_cen;
            tick(1);
            n++;
            hit = prev && d_h == h && d_v == v;
        end
        chk($sformatf("reach_def_%0d_%0d", h, v), 32'(hit), 32'd1);
    endtask

    task automatic run_sm(input int h, input int v);
        logic prev;
        logic hit = 1'b0;
        int n = 0;
        while (!hit && n < 400) begin
            prev = s_cen;
            tick(1);
            n++;
            hit = prev && s_h == h && s_v == v;
        end
        chk($sformatf("reach_sm_%0d_%0d", h, v), 32'(hit), 32'd1);
    endtask

    initial begin
        int c1, c2;
        tick(3);
        chk("rst_hdump", 32'(d_h), 32'd0);
        chk("rst_vdump", 32'(d_v), 32'd16);
        chk("rst_vrender", 32'(d_vr), 32'd17);
        chk("rst_frame", 32'(d_fc), 32'd0);
        chk("rst_lhbl", 32'(d_lh), 32'd1);
        chk("rst_lvbl", 32'(d_lv), 32'd1);
        chk("rst_lhbl_dly", 32'(d_lhd), 32'd1);
        chk("rst_lvbl_dly", 32'(d_lvd), 32'd1);
        chk("rst_hs_vs", 32'({d_hs, d_vs}), 32'd0);
        chk("rst_inits", 32'({d_hi, d_vi}), 32'd0);
        chk("rst_cens", 32'({d_cen, d_cen2}), 32'd0);
        chk("rst_sm_vdump", 32'(s_v), 32'd2);
        chk("rst_sm_lvbl", 32'({s_lv, s_lvd, z_lvd}), 32'd0);
        chk("rst_sm_lhbl", 32'({s_lh, s_lhd, z_lhd}), 32'd7);

        rst_d = 1'b0;
        tick(3);
        chk("rel_cen2_first", 32'({d_cen, d_cen2}), 32'd1);
        tick(4);
        chk("rel_cen_first", 32'(d_cen), 32'd1);
        chk("rel_hdump_hold", 32'(d_h), 32'd0);
        tick(1);
        chk("rel_hdump_1", 32'(d_h), 32'd1);
        chk("rel_cen_low", 32'(d_cen), 32'd0);

        run_def(255, 16);
        chk("lhbl_255", 32'(d_lh), 32'd1);
        tick(8);
        chk("lhbl_256", 32'(d_lh), 32'd0);
        chk("lhbl_dly_256", 32'(d_lhd), 32'd1);
        tick(8);
        chk("lhbl_dly_257", 32'(d_lhd), 32'd1);
        tick(8);
        chk("lhbl_dly_258", 32'(d_lhd), 32'd0);
        run_def(299, 16);
        chk("hs_299", 32'(d_hs), 32'd0);
        tick(8);
        chk("hs_300", 32'(d_hs), 32'd1);
        run_def(331, 16);
        chk("hs_331", 32'(d_hs), 32'd1);
        tick(8);
        chk("hs_332", 32'(d_hs), 32'd0);
        run_def(383, 16);
        chk("lhbl_383", 32'(d_lh), 32'd0);
        chk("vrender_383", 32'(d_vr), 32'd17);
        tick(8);
        chk("wrap_hdump", 32'(d_h), 32'd0);
        chk("wrap_vdump", 32'(d_v), 32'd17);
        chk("wrap_vrender", 32'(d_vr), 32'd18);
        chk("wrap_hinit", 32'(d_hi), 32'd1);
        chk("wrap_vinit", 32'(d_vi), 32'd0);
        chk("wrap_lhbl", 32'(d_lh), 32'd1);
        chk("wrap_lhbl_dly", 32'(d_lhd), 32'd0);
        c1 = 0;
        c2 = 0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            c1 += int'(d_cen);
            c2 += int'(d_cen2);
        end
        chk("cen_per_8", 32'(c1), 32'd1);
        chk("cen2_per_8", 32'(c2), 32'd2);
        chk("hdump_after_8", 32'(d_h), 32'd1);
        chk("hinit_clear", 32'(d_hi), 32'd0);

        rst_s = 1'b0;
        tick(1);
        chk("sm_rel_cen", 32'({s_cen, s_h}), 32'h20);
        tick(1);
        chk("sm_rel_hdump", 32'(s_h), 32'd1);
        run_sm(0, 3);
        chk("sm_line3_lvbl", 32'(s_lv), 32'd1);
        chk("sm_line3_vrender", 32'(s_vr), 32'd4);
        chk("sm_line3_lvbl_dly", 32'({s_lvd, z_lvd}), 32'b01);
        tick(4);
        chk("sm_lvbl_dly_h2", 32'(s_lvd), 32'd1);
        run_sm(8, 3);
        chk("sm_lhbl_8", 32'({s_lh, s_lhd, z_lhd}), 32'b010);
        tick(2);
        chk("sm_hs_9", 32'(s_hs), 32'd1);
        tick(2);
        chk("sm_lhbl_dly_10", 32'({s_lhd, s_hs}), 32'b01);
        tick(2);
        chk("sm_hs_11", 32'(s_hs), 32'd0);
        run_sm(8, 6);
        chk("sm_vs_pre", 32'(s_vs), 32'd0);
        tick(2);
        chk("sm_vs_rise", 32'(s_vs), 32'd1);
        run_sm(0, 8);
        chk("sm_lvbl_8", 32'({s_lv, s_vs}), 32'b01);
        run_sm(8, 8);
        chk("sm_vs_hold", 32'(s_vs), 32'd1);
        tick(2);
        chk("sm_vs_fall", 32'(s_vs), 32'd0);
        run_sm(0, 9);
        chk("sm_vrender_last", 32'(s_vr), 32'd2);
        run_sm(0, 2);
        chk("sm_vinit", 32'({s_hi, s_vi}), 32'b11);
        chk("sm_frame_1", 32'(s_fc), 32'd1);
        tick(2);
        chk("sm_vinit_clear", 32'({s_hi, s_vi, s_fc}), 32'd1);

        run_sm(4, 5);
        rst_s = 1'b1;
        tick(1);
        chk("mid_rst_pos", 32'({s_h, s_v}), 32'd2);
        chk("mid_rst_frame", 32'(s_fc), 32'd0);
        chk("mid_rst_vrender", 32'(s_vr), 32'd3);
        rst_s = 1'b0;
        tick(1);
        chk("mid_rel_cen", 32'({s_cen, s_h}), 32'h20);
        tick(1);
        chk("mid_rel_hdump", 32'({s_cen, s_h}), 32'd1);

        for (int i = 0; i < 255; i++) run_sm(0, 2);
        chk("frame_255", 32'(s_fc), 32'd255);
        run_sm(0, 2);
        chk("frame_wrap", 32'(s_fc), 32'd0);
        chk("frame_wrap_vinit", 32'({s_vi, s_h, s_v}), 32'h402);
        chk("s0_frame_wrap", 32'(z_fc), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
